// File: rtl/fft_pkg.sv
// Shared constants, state encoding and butterfly address arithmetic
// for the radix-2 DIT FFT stage sequencer.
package fft_pkg;

   localparam int N       = 256;
   localparam int SIZE    = 8;
   localparam int STAGE_W = $clog2(SIZE);
   localparam int TW_W    = SIZE - 1;
   localparam int TW_LAT  = 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   function automatic logic [STAGE_W-1:0] sat_stage(
      input logic [STAGE_W-1:0] s
   );
      return (32'(s) > SIZE - 1) ? STAGE_W'(SIZE - 1) : s;
   endfunction

   // Returns {addr_a, addr_b, tw_idx} for butterfly k of stage s.
   function automatic logic [SIZE+SIZE+TW_W-1:0] bfly_addr(
      input logic [TW_W-1:0]    k,
      input logic [STAGE_W-1:0] s
   );
      logic [TW_W-1:0] mask;
      logic [TW_W-1:0] j;
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      logic [TW_W-1:0] tw;
      mask = TW_W'((32'd1 << s) - 32'd1);
      j    = k & mask;
      a    = (({1'b0, k} >> s) << (s + 1)) | {1'b0, j};
      b    = a + (SIZE'(1) << s);
      tw   = j << (STAGE_W'(SIZE - 1) - s);
      return {a, b, tw};
   endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational butterfly address generator: (k, s) to operand
// addresses and twiddle index.
module fft_bfly_addr_gen
   import fft_pkg::*;
(
   input  logic [TW_W-1:0]    k,
   input  logic [STAGE_W-1:0] s,
   output logic [SIZE-1:0]    addr_a,
   output logic [SIZE-1:0]    addr_b,
   output logic [TW_W-1:0]    tw_idx
);

   assign {addr_a, addr_b, tw_idx} = bfly_addr(k, s);

endmodule

// File: rtl/fft_stage_addr_ctrl.sv
// Radix-2 DIT FFT stage sequencer with valid/ready output.
// Define FFT_AUTO_STAGE_EN to run all stages from a single start.
module fft_stage_addr_ctrl
   import fft_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [STAGE_W-1:0] stage_sel,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [SIZE-1:0]    addr_a,
   output logic [SIZE-1:0]    addr_b,
   output logic [TW_W-1:0]    tw_idx,
   output logic               tw_en,
   output logic [STAGE_W-1:0] stage_out,
   output logic               busy,
   output logic               done
);

   localparam logic [TW_W-1:0] K_LAST = '1;

   state_t             state;
   state_t             state_nx;
   logic [TW_W-1:0]    k;
   logic [STAGE_W-1:0] s;
   logic [SIZE-1:0]    gen_a;
   logic [SIZE-1:0]    gen_b;
   logic [TW_W-1:0]    gen_tw;
   logic               adv;
   logic               accept;
   logic               last;
   logic               stage_wrap;

   fft_bfly_addr_gen u_gen (
      .k      (k),
      .s      (s),
      .addr_a (gen_a),
      .addr_b (gen_b),
      .tw_idx (gen_tw)
   );

   assign adv    = !out_valid || out_ready;
   assign accept = out_valid && out_ready;
   assign last   = (k == K_LAST);
   assign busy   = (state == RUN) || (state == DRAIN);

`ifdef FFT_AUTO_STAGE_EN
   assign stage_wrap = last && (s != STAGE_W'(SIZE - 1));
`else
   assign stage_wrap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      tw_en    = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nx = RUN;
         RUN: begin
            tw_en = adv;
            if (adv && last && !stage_wrap) state_nx = DRAIN;
         end
         DRAIN: if (accept) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ROM is enabled on the same edge that loads these, so they line up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= '0;
         s         <= '0;
         out_valid <= 1'b0;
         addr_a    <= '0;
         addr_b    <= '0;
         tw_idx    <= '0;
         stage_out <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (state == IDLE && start) begin
            k <= '0;
`ifdef FFT_AUTO_STAGE_EN
            s <= '0;
`else
            s <= sat_stage(stage_sel);
`endif
         end else if (state == RUN && adv) begin
            out_valid <= 1'b1;
            addr_a    <= gen_a;
            addr_b    <= gen_b;
            tw_idx    <= gen_tw;
            stage_out <= s;
            k         <= k + 1'b1;
            if (stage_wrap) s <= s + 1'b1;
         end else if (state == DRAIN && accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_stage_addr_ctrl.sv
// Scoreboard bench for fft_stage_addr_ctrl: expected beats are queued
// at start, a negedge monitor pops and compares accepted beats.
module tb_fft_stage_addr_ctrl;
   import fft_pkg::*;

`ifdef FFT_AUTO_STAGE_EN
   localparam int RUN_BEATS = (N / 2) * SIZE;
`else
   localparam int RUN_BEATS = N / 2;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               start = 1'b0;
   logic [STAGE_W-1:0] stage_sel = '0;
   logic               out_ready = 1'b1;
   logic               out_valid;
   logic [SIZE-1:0]    addr_a;
   logic [SIZE-1:0]    addr_b;
   logic [TW_W-1:0]    tw_idx;
   logic               tw_en;
   logic [STAGE_W-1:0] stage_out;
   logic               busy;
   logic               done;

   fft_stage_addr_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stage_sel (stage_sel),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .tw_idx    (tw_idx),
      .tw_en     (tw_en),
      .stage_out (stage_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int k;
      int a;
      int b;
      int tw;
   } beat_t;

   beat_t q[$];
   beat_t mon_e;
   int checks = 0;
   int errors = 0;
   int beats = 0;
   int done_exp = 0;
   int cyc = 0;
   int last_beat_cyc = -100;

   // Hand-computed (stage, k) -> (a, b, tw) vectors.
   int dir_s[5]  = '{0, 0, 2, 2, 7};
   int dir_k[5]  = '{0, 127, 5, 4, 127};
   int dir_a[5]  = '{0, 254, 9, 8, 127};
   int dir_b[5]  = '{1, 255, 13, 12, 255};
   int dir_tw[5] = '{0, 0, 32, 0, 127};

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   function automatic beat_t exp_beat(int s, int k);
      beat_t e;
      int h;
      int j;
      h    = 1 << s;
      j    = k % h;
      e.s  = s;
      e.k  = k;
      e.a  = (k / h) * 2 * h + j;
      e.b  = e.a + h;
      e.tw = j * (N / (2 * h));
      return e;
   endfunction

   task automatic push_run(int s);
      int st;
      st = (s > SIZE - 1) ? SIZE - 1 : s;
`ifdef FFT_AUTO_STAGE_EN
      for (int ss = 0; ss < SIZE; ss++)
         for (int k = 0; k < N / 2; k++)
            q.push_back(exp_beat(ss, k));
`else
      for (int k = 0; k < N / 2; k++)
         q.push_back(exp_beat(st, k));
`endif
      done_exp++;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("addr_a", int'(addr_a), mon_e.a);
            chk("addr_b", int'(addr_b), mon_e.b);
            chk("tw_idx", int'(tw_idx), mon_e.tw);
            chk("stage_out", int'(stage_out), mon_e.s);
            for (int i = 0; i < 5; i++)
               if (mon_e.s == dir_s[i] && mon_e.k == dir_k[i]) begin
                  chk("dir_a", int'(addr_a), dir_a[i]);
                  chk("dir_b", int'(addr_b), dir_b[i]);
                  chk("dir_tw", int'(tw_idx), dir_tw[i]);
               end
         end
         beats++;
         last_beat_cyc = cyc;
      end
      if (rst_n && done) begin
         if (done_exp == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            done_exp--;
            chk("done_latency", cyc - last_beat_cyc, 2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(int s);
      stage_sel = STAGE_W'(s);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("first_tw_en", int'(tw_en), 1);
      chk("first_valid_low", int'(out_valid), 0);
      chk("busy_run", int'(busy), 1);
      tick();
      chk("first_valid_high", int'(out_valid), 1);
   endtask

   task automatic wait_beats(int b0, int n, int bound);
      int i = 0;
      while (beats - b0 < n && i < bound) begin
         tick();
         i++;
      end
      if (beats - b0 < n)
         chk("beat_timeout", beats - b0, n);
   endtask

   task automatic wait_done(int bound);
      int i = 0;
      while (done_exp != 0 && i < bound) begin
         tick();
         i++;
      end
      if (done_exp != 0) begin
         chk("done_timeout", done_exp, 0);
         done_exp = 0;
      end
      tick();
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int b0;
      int ra;
      int rb;
      int rt;
      int rs;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_addr_a", int'(addr_a), 0);
      chk("rst_addr_b", int'(addr_b), 0);
      chk("rst_tw_idx", int'(tw_idx), 0);
      chk("rst_stage_out", int'(stage_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tw_en", int'(tw_en), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Stage 0, free-running sink.
      b0 = beats;
      push_run(0);
      run_start(0);
      wait_done(RUN_BEATS + 50);
      chk("beats_stage0", beats - b0, RUN_BEATS);

      // Stage 2 with a 5-cycle stall on k=10.
      b0 = beats;
      push_run(2);
      run_start(2);
      wait_beats(b0, 10, 100);
      out_ready = 1'b0;
      ra = int'(addr_a);
      rb = int'(addr_b);
      rt = int'(tw_idx);
      rs = int'(stage_out);
`ifdef FFT_AUTO_STAGE_EN
      chk("bp_a", ra, 20);
      chk("bp_b", rb, 21);
      chk("bp_tw", rt, 0);
`else
      chk("bp_a", ra, 18);
      chk("bp_b", rb, 22);
      chk("bp_tw", rt, 64);
`endif
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_tw_en", int'(tw_en), 0);
         chk("bp_hold_a", int'(addr_a), ra);
         chk("bp_hold_b", int'(addr_b), rb);
         chk("bp_hold_tw", int'(tw_idx), rt);
         chk("bp_hold_stage", int'(stage_out), rs);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_done(RUN_BEATS + 50);
      chk("beats_stage2", beats - b0, RUN_BEATS);

      // Stage 7 with a stray start (stage_sel=5) mid-run.
      b0 = beats;
      push_run(7);
      run_start(7);
      repeat (20) tick();
      stage_sel = STAGE_W'(5);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("stray_start_busy", int'(busy), 1);
      wait_done(RUN_BEATS + 50);
      chk("beats_stage7", beats - b0, RUN_BEATS);

      // Reset at k=60 of a stage-1 run.
      b0 = beats;
      push_run(1);
      run_start(1);
      wait_beats(b0, 60, 200);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_tw_en", int'(tw_en), 0);
      chk("mid_rst_addr_a", int'(addr_a), 0);
      q.delete();
      done_exp = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();

      // Fresh run after reset starts at k=0.
      b0 = beats;
      push_run(3);
      run_start(3);
      wait_done(RUN_BEATS + 50);
      chk("beats_stage3", beats - b0, RUN_BEATS);

      chk("queue_empty", q.size(), 0);
      chk("done_idle", int'(done), 0);
      chk("busy_idle", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_stage_addr_ctrl.md
Name: fft_stage_addr_ctrl

Overview:
- Sequencer for one radix-2 DIT FFT stage of the N-point pipeline.
- Per butterfly, it generates the operand-pair read addresses for the data RAM and the twiddle ROM index, and drives the twiddle ROM enable.
- Addresses are registered so they arrive aligned with the 1-cycle-latency twiddle ROM output.
- Sits between the top-level FFT control FSM and the butterfly/memory datapath; a valid/ready handshake lets the butterfly stall it.

Parameters:
- N, 256, FFT length (power of 2).
- SIZE, 8, log2(N); address width.
- TW_LAT, 1, twiddle ROM read latency in cycles; only 1 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a stage run; ignored unless in IDLE.
- stage_sel  in  $clog2(SIZE)  stage index s, 0..SIZE-1; sampled with start.
- out_ready  in  1  butterfly accepts the current output.
- out_valid  out  1  addr_a/addr_b/tw_idx/stage_out are valid.
- addr_a  out  SIZE  upper-leg data address.
- addr_b  out  SIZE  lower-leg data address.
- tw_idx  out  SIZE-1  twiddle index in units of 2*pi/N (range 0..N/2-1).
- tw_en  out  1  twiddle ROM read enable, combinational from state and advance.
- stage_out  out  $clog2(SIZE)  stage of the current output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the stage run completes.

Behaviour:
- Reset values (async): state=IDLE; k=0; out_valid=0; addr_a=0; addr_b=0; tw_idx=0; stage_out=0; busy=0; done=0. tw_en is 0 in reset.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1; latch s=stage_sel; k=0.
  - RUN: adv = !out_valid || out_ready.
    - tw_en = adv.
    - On adv, the output registers load the values for k and k increments.
    - When k=N/2-1 is issued -> DRAIN.
  - DRAIN: tw_en=0; wait until out_valid && out_ready -> DONE, with out_valid dropping to 0.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Address arithmetic for butterfly k (SIZE-1 bits, 0..N/2-1):
  - j = k & ((1<<s)-1)
  - addr_a = ((k>>s)<<(s+1)) | j
  - addr_b = addr_a + (1<<s)
  - tw_idx = j << (SIZE-1-s)
  - All arithmetic is unsigned with no overflow, since addr_b is at most N-1.
- Latency:
  - start sampled at edge E0.
  - tw_en is high in the following cycle.
  - At edge E1, out_valid rises with k=0 outputs, coincident with the ROM cos/sin for tw_idx.
  - With out_ready held at 1: N/2 consecutive valid beats, then done 2 cycles after the last beat is accepted.
- Back-pressure: while out_valid && !out_ready, all outputs hold, k holds, and tw_en=0, so the ROM holds its data.
- start while busy or in DONE: ignored; stage_sel changes mid-run: ignored.
- rst_n low mid-run: immediate return to the reset values; no done pulse.
- stage_sel >= SIZE: treated as SIZE-1 (saturate).

Optional Feature:
- Macro: FFT_AUTO_STAGE_EN.
- Defined:
  - start runs all stages 0..SIZE-1 back to back; stage_sel is ignored.
  - On the last butterfly of stage s<SIZE-1, s increments and k=0 without leaving RUN. The inter-stage gap is zero cycles; the downstream stage hazard is the datapath's concern.
  - done pulses only after stage SIZE-1 drains.
  - stage_out tracks the stage of the current output beat.
- Undefined: single-stage run as above.

Decomposition:
- Shared package fft_pkg: N, SIZE, STAGE_W=$clog2(SIZE), the state encoding enum (IDLE/RUN/DRAIN/DONE), and a function bfly_addr(k,s) returning {addr_a, addr_b, tw_idx}, reused by the bench's reference model.
- One natural sub-module: fft_bfly_addr_gen, purely combinational k,s -> addresses. The FSM, counter and output registers stay in fft_stage_addr_ctrl.

Test Plan:
- Stage 0, out_ready=1: beat k=0 -> a=0, b=1, tw=0; k=127 -> a=254, b=255, tw=0; exactly 128 beats; done 2 cycles after the last beat.
- Stage 2: k=5 -> a=9, b=13, tw=32; k=4 -> a=8, b=12, tw=0. Stage 7: k=127 -> a=127, b=255, tw=127.
- Back-pressure: hold out_ready=0 for 5 cycles at k=10 -> outputs stable, tw_en=0 throughout; resume -> k=11 on the next beat with no beat lost or duplicated.
- Reset mid-run: assert rst_n=0 at k=60 -> out_valid=0, busy=0 asynchronously; no done pulse; a new start runs from k=0.
- start pulsed during RUN with stage_sel=5 -> ignored; the run completes for the original stage, with 128 beats and one done pulse.
- FFT_AUTO_STAGE_EN: a single start -> 1024 beats, stage_out steps 0..7 every 128 beats, one done pulse at the end.
